// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-read-port register file
//
// General-purpose storage for the SHA-256 datapath. It supports byte-masked
// writes, NRD independent read ports, an optional registered read with
// write-first bypass, an optional hardwired-zero entry 0, and a sequenced
// bulk-clear engine.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (zeroes array, rdata regs, FSM)
//   we       in   write enable (ignored while busy)
//   waddr    in   [ADDR_W]     write address
//   wdata    in   [WIDTH]      write data
//   wmask    in   [WIDTH/8]    byte-lane enables, bit k gates wdata[8k+7:8k]
//   raddr    in   [NRD*ADDR_W] packed read addresses, port p at p*ADDR_W
//   rdata    out  [NRD*WIDTH]  packed read data, port p at p*WIDTH
//   clr_req  in   single-cycle request to zero the whole array
//   busy     out  high for exactly DEPTH cycles while the clear engine runs
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 6,
    parameter int NRD      = 2,
    parameter int READ_REG = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [WIDTH/8-1:0]      wmask,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*WIDTH-1:0]    rdata,
    input  logic                    clr_req,
    output logic                    busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NBYTE = WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clrState_t;

    clrState_t          clrState;
    logic [ADDR_W-1:0]  clrCnt;

    logic [WIDTH-1:0]   memRd [DEPTH];
    logic [WIDTH-1:0]   oldWord;
    logic [WIDTH-1:0]   mergedWord;
    logic               writeCommit;
    logic               clearing;

    // Writes only land while idle; entry 0 never accepts data in zero-reg mode.
    assign writeCommit = we && (clrState == IDLE)
                         && !((ZERO_REG != 0) && (waddr == '0));
    assign clearing    = (clrState == CLEAR);

    // Byte-lane merge of the incoming word onto the currently stored word.
    assign oldWord = memRd[waddr];

    genvar gi;
    generate
        for (gi = 0; gi < NBYTE; gi++) begin : gLane
            assign mergedWord[gi*8 +: 8] = wmask[gi] ? wdata[gi*8 +: 8]
                                                     : oldWord[gi*8 +: 8];
        end
    endgenerate

    // Clear sequencer. busy is registered alongside the state so it rises the
    // cycle after clr_req and falls the cycle after the last entry is zeroed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clrState <= IDLE;
            clrCnt   <= '0;
            busy     <= 1'b0;
        end else begin
            case (clrState)
                IDLE: begin
                    if (clr_req) begin
                        clrState <= CLEAR;
                        clrCnt   <= '0;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    clrCnt <= clrCnt + 1'b1;
                    // Exit on the all-ones count; the counter then wraps to 0.
                    if (&clrCnt) begin
                        clrState <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    clrState <= IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Storage: one register per entry so the async reset can zero the whole
    // array at once. Clear and write are mutually exclusive (write needs IDLE).
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gEntry
            logic [WIDTH-1:0] word;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    word <= '0;
                end else if (clearing && (clrCnt == ADDR_W'(gi))) begin
                    word <= '0;
                end else if (writeCommit && (waddr == ADDR_W'(gi))) begin
                    word <= mergedWord;
                end
            end

            assign memRd[gi] = word;
        end
    endgenerate

    // Read ports.
    generate
        for (gi = 0; gi < NRD; gi++) begin : gRdPort
            logic [ADDR_W-1:0] ra;
            logic [WIDTH-1:0]  curWord;

            assign ra      = raddr[gi*ADDR_W +: ADDR_W];
            assign curWord = ((ZERO_REG != 0) && (ra == '0)) ? '0 : memRd[ra];

            if (READ_REG != 0) begin : gReg
                logic [WIDTH-1:0] nextWord;
                logic [WIDTH-1:0] rdReg;

                // Capture what the entry will hold after this edge: the entry
                // being cleared reads 0, a committing write is bypassed in.
                always_comb begin
                    nextWord = curWord;
                    if (clearing && (clrCnt == ra)) begin
                        nextWord = '0;
                    end else if (writeCommit && (waddr == ra)) begin
                        nextWord = mergedWord;
                    end
                end

                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        rdReg <= '0;
                    end else begin
                        rdReg <= nextWord;
                    end
                end

                assign rdata[gi*WIDTH +: WIDTH] = rdReg;
            end else begin : gComb
                assign rdata[gi*WIDTH +: WIDTH] = curWord;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp
//
// Instance dut uses the defaults (64 x 32, two ports, registered read).
// Instance dutZ uses ZERO_REG=1 with three read ports.
// A plain array model tracks array contents; expected registered reads are
// the model contents after the edge at which the read address was sampled.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [11:0] raddr;
    logic [63:0] rdata;
    logic        clr_req;
    logic        busy;

    logic        weZ;
    logic [5:0]  waddrZ;
    logic [31:0] wdataZ;
    logic [3:0]  wmaskZ;
    logic [17:0] raddrZ;
    logic [95:0] rdataZ;
    logic        clrReqZ;
    logic        busyZ;

    logic [31:0] model [DEPTH];
    int          clearLeft;
    int          clearPos;
    int          checks = 0;
    int          errors = 0;
    int          busyCycles;
    int          guard;

    always #5 clock = ~clock;

    regfile_mp dut (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .wmask   (wmask),
        .raddr   (raddr),
        .rdata   (rdata),
        .clr_req (clr_req),
        .busy    (busy)
    );

    regfile_mp #(.NRD(3), .ZERO_REG(1)) dutZ (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (weZ),
        .waddr   (waddrZ),
        .wdata   (wdataZ),
        .wmask   (wmaskZ),
        .raddr   (raddrZ),
        .rdata   (rdataZ),
        .clr_req (clrReqZ),
        .busy    (busyZ)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (mask[k]) r[k*8 +: 8] = data[k*8 +: 8];
        return r;
    endfunction

    // Apply the edge's effect to the model, then advance past the edge.
    task automatic step();
        if (clearLeft > 0) begin
            model[clearPos] = 32'h0;
            clearPos++;
            clearLeft--;
        end else begin
            if (we) model[waddr] = merge(model[waddr], wdata, wmask);
            if (clr_req) begin
                clearLeft = DEPTH;
                clearPos  = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic checkReads(input string tag);
        check({tag, "_p0"}, rdata[31:0],  model[raddr[5:0]]);
        check({tag, "_p1"}, rdata[63:32], model[raddr[11:6]]);
        check({tag, "_busy"}, busy, (clearLeft > 0));
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        clearLeft = 0;
        clearPos  = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0; wmask = '0; raddr = '0; clr_req = 1'b0;
        weZ = 1'b0; waddrZ = '0; wdataZ = '0; wmaskZ = '0; raddrZ = '0; clrReqZ = 1'b0;
        modelReset();
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", rdata, 64'h0);
        check("rst_busyZ", busyZ, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Reset state: every address reads zero on both ports.
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {6'(63 - a), 6'(a)};
            step();
            checkReads("rst_read");
        end

        // Byte-masked partial write.
        we = 1'b1; waddr = 6'd5; wdata = 32'hDEADBEEF; wmask = 4'hF;
        step();
        wdata = 32'h00001234; wmask = 4'b0011;
        step();
        we = 1'b0; raddr = {6'd5, 6'd5};
        step();
        check("mask_merge", rdata[31:0], 32'hDEAD1234);
        checkReads("mask_merge");

        // Write-first bypass on both ports.
        we = 1'b1; waddr = 6'd9; wdata = 32'hCAFEF00D; wmask = 4'hF; raddr = {6'd9, 6'd9};
        step();
        check("bypass_p0", rdata[31:0], 32'hCAFEF00D);
        check("bypass_p1", rdata[63:32], 32'hCAFEF00D);
        we = 1'b0;

        // Randomized writes/reads against the model.
        for (int n = 0; n < 300; n++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 6'($urandom_range(0, 63));
            wdata = $urandom;
            wmask = 4'($urandom_range(0, 15));
            raddr[5:0]  = ($urandom_range(0, 1) == 1) ? waddr : 6'($urandom_range(0, 63));
            raddr[11:6] = ($urandom_range(0, 1) == 1) ? waddr : 6'($urandom_range(0, 63));
            step();
            checkReads("rand");
        end
        we = 1'b0;

        // Fill every entry with its index, then clear.
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = 6'(i); wdata = 32'(i); wmask = 4'hF;
            step();
        end
        // A write in the clr_req cycle still commits.
        we = 1'b1; waddr = 6'd7; wdata = 32'hA5A5A5A5; wmask = 4'hF;
        raddr = {6'd7, 6'd7}; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("clr_start_wr", rdata[31:0], 32'hA5A5A5A5);
        check("clr_start_busy", busy, 1'b1);
        busyCycles = (busy === 1'b1) ? 1 : 0;
        guard = 0;
        // Writes to addr 3 are attempted throughout and must be dropped.
        while (busy === 1'b1 && guard < 100) begin
            we = 1'b1; waddr = 6'd3; wdata = 32'hFFFFFFFF; wmask = 4'hF;
            raddr[5:0]  = ($urandom_range(0, 1) == 1) ? 6'd3 : 6'($urandom_range(0, 63));
            raddr[11:6] = 6'(clearPos);
            step();
            checkReads("clr_busy");
            if (busy === 1'b1) busyCycles++;
            guard++;
        end
        we = 1'b0;
        check("clr_busy_len", busyCycles, 64);
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {6'(a), 6'(a)};
            step();
            check("clr_all_zero", rdata, 64'h0);
        end

        // Reset in the middle of a clear.
        for (int n = 0; n < 10; n++) begin
            we = 1'b1; waddr = 6'($urandom_range(20, 63)); wdata = $urandom; wmask = 4'hF;
            step();
        end
        we = 1'b0; raddr = {6'd50, 6'd40}; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int n = 0; n < 20; n++) step();
        check("midclr_busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midclr_busy_rst", busy, 1'b0);
        check("midclr_rdata_rst", rdata, 64'h0);
        modelReset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        we = 1'b1; waddr = 6'd10; wdata = 32'h12345678; wmask = 4'hF; raddr = {6'd10, 6'd10};
        step();
        check("midclr_newwr", rdata[31:0], 32'h12345678);
        we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {6'(a), 6'(63 - a)};
            step();
            checkReads("midclr_read");
        end

        // Hardwired zero entry with three read ports.
        weZ = 1'b1; waddrZ = 6'd0; wdataZ = 32'hFFFFFFFF; wmaskZ = 4'hF;
        raddrZ = {6'd0, 6'd0, 6'd0};
        step();
        check("zero_bypass", rdataZ, 96'h0);
        waddrZ = 6'd1; raddrZ = {6'd0, 6'd1, 6'd0};
        step();
        check("zero_wr1_bypass", rdataZ, {32'h0, 32'hFFFFFFFF, 32'h0});
        weZ = 1'b0;
        step();
        check("zero_read", rdataZ, {32'h0, 32'hFFFFFFFF, 32'h0});
        check("zero_busy", busyZ, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file. It is the general-purpose storage block for the SHA-256 datapath (message schedule words W[0..63], working variables, constants scratch).
- Adds byte-masked writes, N independent read ports, an optional registered read with write-first bypass, an optional hardwired-zero entry, and a sequenced bulk-clear engine with a busy flag.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries (default 64)
NRD, 2, number of independent read ports (1..4)
READ_REG, 1, 1 = registered read (1-cycle latency); 0 = combinational read
ZERO_REG, 0, 1 = entry 0 is hardwired to zero and writes to it are dropped

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  WIDTH  write data
wmask  in  WIDTH/8  byte-lane enables; bit k gates wdata[8k+7:8k]
raddr  in  NRD*ADDR_W  packed read addresses; port p = raddr[p*ADDR_W +: ADDR_W]
rdata  out  NRD*WIDTH  packed read data; port p = rdata[p*WIDTH +: WIDTH]
clr_req  in  1  single-cycle request to zero the whole array
busy  out  1  high while the clear engine runs

Behaviour:
- Reset: reset_n low asynchronously zeroes every entry, the rdata registers (READ_REG=1), the clear counter and busy; FSM enters IDLE. Reset asserted mid-clear aborts the clear; the array is zero regardless.
- Write: at a rising edge with we=1, FSM in IDLE and reset_n high, entry[waddr] byte lane k takes wdata lane k where wmask[k]=1; other lanes hold. wmask=0 is a no-op.
- ZERO_REG=1: writes with waddr=0 are dropped. Every read of address 0 returns 0, including through the bypass.
- Read, READ_REG=0: rdata port p = entry[raddr_p] combinationally. A same-cycle write is visible only after the edge.
- Read, READ_REG=1: rdata port p is registered at each edge from entry[raddr_p], so latency is 1 cycle.
  - Write-first bypass: if a write commits at that edge to raddr_p, the register captures the merged value (new lanes where wmask=1, old lanes elsewhere).
  - All ports are independent; any number of ports may read the same address.
- Clear FSM states:
  - IDLE: clr_req=1 at an edge -> CLEAR, counter=0, busy=1 from the next cycle. A write in that same cycle still commits before the clear starts.
  - CLEAR: each edge zeroes entry[counter] and increments the counter. When counter=DEPTH-1 that entry is zeroed -> IDLE, busy=0 next cycle. busy is high for exactly DEPTH cycles.
  - While busy: we is ignored (dropped, not queued), clr_req is ignored, and reads return current array contents (partially cleared). With READ_REG=1, a read of the entry being cleared that edge captures 0.
- Counter wrap: the counter is ADDR_W bits wide. The exit is decoded on all-ones, not on overflow.
- No undefined addresses exist (DEPTH = 2**ADDR_W).

Test Plan:
1. Reset with defaults, read all 64 addresses on both ports -> every rdata = 0x00000000; busy = 0.
2. Write 0xDEADBEEF to addr 5 with wmask=4'hF, then write 0x00001234 to addr 5 with wmask=4'b0011; read addr 5 -> 0xDEAD1234.
3. READ_REG=1: set raddr0=raddr1=9 and write 0xCAFEF00D to addr 9 in the same cycle -> both rdata = 0xCAFEF00D one cycle later (bypass).
4. Fill all 64 entries with their index, pulse clr_req, and attempt a write to addr 3 while busy:
   - busy is high for exactly 64 cycles;
   - the write to addr 3 is dropped;
   - all entries read 0 afterwards.
5. Mid-clear (cycle 20 of CLEAR) assert reset_n=0 for 1 cycle -> busy falls immediately, all entries 0, FSM IDLE, and a new write/read works on the next cycle.
6. ZERO_REG=1, NRD=3: write 0xFFFFFFFF to addr 0 and addr 1, read addrs {0,1,0} -> rdata = {0, 0xFFFFFFFF, 0}.
